// File: rtl/conf_int_mac_pkg.sv
// Shared types, default widths and the saturation helper for the dot-product MAC sequencer.
package conf_int_mac_pkg;

    localparam int DEF_DATA_PATH_BITWIDTH = 16;
    localparam int DEF_LEN_BITWIDTH       = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Largest unsigned value representable in w bits (w < 64).
    function automatic logic [63:0] sat_max(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/conf_int_mac_dot_seq_if.sv
// Command, operand-stream and result handshakes between producer/consumer and the sequencer.
interface conf_int_mac_dot_seq_if
    import conf_int_mac_pkg::*;
#(
    parameter int DATA_PATH_BITWIDTH = DEF_DATA_PATH_BITWIDTH,
    parameter int LEN_BITWIDTH       = DEF_LEN_BITWIDTH
);
    logic                          start;
    logic [LEN_BITWIDTH-1:0]       len;
    logic [DATA_PATH_BITWIDTH-1:0] bias;
    logic                          busy;
    logic                          in_valid;
    logic                          in_ready;
    logic [DATA_PATH_BITWIDTH-1:0] a;
    logic [DATA_PATH_BITWIDTH-1:0] b;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_PATH_BITWIDTH-1:0] d;
    logic [LEN_BITWIDTH-1:0]       count;
    logic                          ovf;

    modport master (
        output start, len, bias, in_valid, a, b, out_ready,
        input  busy, in_ready, out_valid, d, count, ovf
    );

    modport slave (
        input  start, len, bias, in_valid, a, b, out_ready,
        output busy, in_ready, out_valid, d, count, ovf
    );
endinterface

// File: rtl/conf_int_mac_dot_dp.sv
// Combinational MAC step: next accumulator = acc + a*b at full width, plus overflow.
// CONF_INT_MAC_SAT_EN selects clamping at the max value instead of modular wrap.
module conf_int_mac_dot_dp
    import conf_int_mac_pkg::*;
#(
    parameter int DATA_PATH_BITWIDTH = DEF_DATA_PATH_BITWIDTH
) (
    input  logic [DATA_PATH_BITWIDTH-1:0] a_i,
    input  logic [DATA_PATH_BITWIDTH-1:0] b_i,
    input  logic [DATA_PATH_BITWIDTH-1:0] acc_i,
    output logic [DATA_PATH_BITWIDTH-1:0] acc_o,
    output logic                          ovf_o
);
    localparam int WIDE = 2 * DATA_PATH_BITWIDTH + 1;
    localparam logic [WIDE-1:0] MAX_WIDE = WIDE'(sat_max(DATA_PATH_BITWIDTH));

    logic [WIDE-1:0] prod;
    logic [WIDE-1:0] sum;

    assign prod  = WIDE'(a_i) * WIDE'(b_i);
    assign sum   = prod + WIDE'(acc_i);
    assign ovf_o = (sum > MAX_WIDE);

`ifdef CONF_INT_MAC_SAT_EN
    // Once clamped, further unsigned additions keep the sum above max, so it stays clamped.
    assign acc_o = ovf_o ? MAX_WIDE[DATA_PATH_BITWIDTH-1:0] : sum[DATA_PATH_BITWIDTH-1:0];
`else
    assign acc_o = sum[DATA_PATH_BITWIDTH-1:0];
`endif

endmodule

// File: rtl/conf_int_mac_dot_seq.sv
// Dot-product sequencer: streams operand pairs into one MAC, feeding the accumulator back.
// Saturating vs wrapping accumulation is chosen by CONF_INT_MAC_SAT_EN in the datapath.
//
// state   | meaning
// --------+-----------------------------------------------------
// ST_IDLE | waiting for start; no handshakes offered
// ST_RUN  | accepting one operand pair per cycle until len pairs
// ST_DONE | result offered on out_valid until out_ready
module conf_int_mac_dot_seq
    import conf_int_mac_pkg::*;
#(
    parameter int DATA_PATH_BITWIDTH = DEF_DATA_PATH_BITWIDTH,
    parameter int LEN_BITWIDTH       = DEF_LEN_BITWIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    conf_int_mac_dot_seq_if.slave        bus
);
    localparam int DW = DATA_PATH_BITWIDTH;
    localparam int LW = LEN_BITWIDTH;

    state_e          state_q, state_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [LW-1:0]   count_q, count_d;
    logic [LW-1:0]   len_q, len_d;
    logic            ovf_q, ovf_d;
    logic [DW-1:0]   dp_acc;
    logic            dp_ovf;
    logic            in_ready;
    logic            out_valid;

    conf_int_mac_dot_dp #(
        .DATA_PATH_BITWIDTH(DW)
    ) u_dp (
        .a_i   (bus.a),
        .b_i   (bus.b),
        .acc_i (acc_q),
        .acc_o (dp_acc),
        .ovf_o (dp_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        count_d   = count_q;
        len_d     = len_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_d   = bus.bias;
                    ovf_d   = 1'b0;
                    count_d = '0;
                    if (bus.len != '0) begin
                        len_d   = bus.len;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    acc_d   = dp_acc;
                    ovf_d   = ovf_q | dp_ovf;
                    count_d = count_q + LW'(1);
                    if (count_q == len_q - LW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.d         = acc_q;
    assign bus.count     = count_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_conf_int_mac_dot_seq.sv
// Self-checking bench for conf_int_mac_dot_seq: directed jobs plus random jobs against a job-level model.
// Expectations follow CONF_INT_MAC_SAT_EN when it is defined for the build.
module tb_conf_int_mac_dot_seq;
    localparam int DW = 16;
    localparam int LW = 8;
    localparam longint unsigned MAXV = 64'd65535;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int unsigned pa [0:255];
    int unsigned pb [0:255];

    conf_int_mac_dot_seq_if #(.DATA_PATH_BITWIDTH(DW), .LEN_BITWIDTH(LW)) m ();

    conf_int_mac_dot_seq #(
        .DATA_PATH_BITWIDTH(DW),
        .LEN_BITWIDTH(LW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One pair of the dot product with plain integer arithmetic.
    function automatic void model_step(input longint unsigned acc_in, input int unsigned a,
                                       input int unsigned b, output longint unsigned acc_out,
                                       output bit ov);
        longint unsigned sum;
        sum = acc_in + longint'(a) * longint'(b);
        ov  = (sum > MAXV);
`ifdef CONF_INT_MAC_SAT_EN
        acc_out = ov ? MAXV : sum;
`else
        acc_out = sum % (MAXV + 1);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int n, input logic [15:0] bias_v, input int gap,
                           input int bp, input bit stray);
        longint unsigned acc;
        longint unsigned acc_nx;
        bit ovf;
        bit ov;
        acc = longint'(bias_v);
        ovf = 1'b0;
        m.start = 1'b1;
        m.len   = LW'(n);
        m.bias  = bias_v;
        tick();
        m.start = 1'b0;
        chk("busy_after_start", m.busy, 1);
        chk("in_ready_after_start", m.in_ready, n != 0);
        chk("out_valid_after_start", m.out_valid, n == 0);
        chk("d_after_start", m.d, acc);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                if (stray && g == 0) begin
                    m.start = 1'b1;
                    m.len   = 8'd1;
                    m.bias  = 16'hAAAA;
                end
                tick();
                m.start = 1'b0;
                chk("stall_count", m.count, i);
                chk("stall_d", m.d, acc);
                chk("stall_in_ready", m.in_ready, 1);
            end
            m.in_valid = 1'b1;
            m.a = DW'(pa[i]);
            m.b = DW'(pb[i]);
            tick();
            m.in_valid = 1'b0;
            model_step(acc, pa[i], pb[i], acc_nx, ov);
            acc = acc_nx;
            ovf = ovf | ov;
            chk("hs_count", m.count, i + 1);
            chk("hs_d", m.d, acc);
            chk("hs_ovf", m.ovf, ovf);
            chk("hs_out_valid", m.out_valid, i == n - 1);
            chk("hs_in_ready", m.in_ready, i != n - 1);
        end
        for (int k = 0; k < bp; k++) begin
            if (stray && k == 0) begin
                m.start = 1'b1;
                m.len   = 8'd3;
                m.bias  = 16'h5555;
            end
            tick();
            m.start = 1'b0;
            chk("bp_out_valid", m.out_valid, 1);
            chk("bp_d", m.d, acc);
            chk("bp_count", m.count, n);
        end
        chk("done_d", m.d, acc);
        chk("done_ovf", m.ovf, ovf);
        chk("done_count", m.count, n);
        m.out_ready = 1'b1;
        m.start     = stray;
        tick();
        m.out_ready = 1'b0;
        m.start     = 1'b0;
        chk("post_out_valid", m.out_valid, 0);
        chk("post_busy", m.busy, 0);
        chk("post_d_hold", m.d, acc);
        chk("post_count_hold", m.count, n);
        chk("post_ovf_hold", m.ovf, ovf);
        tick();
        chk("idle_busy", m.busy, 0);
        chk("idle_in_ready", m.in_ready, 0);
    endtask

    initial begin
        logic [15:0] exp_ovf_d;
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b0;
        m.start     = 1'b0;
        m.len       = '0;
        m.bias      = '0;
        m.in_valid  = 1'b0;
        m.a         = '0;
        m.b         = '0;
        m.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_d", m.d, 0);
        chk("rst_count", m.count, 0);
        chk("rst_ovf", m.ovf, 0);
        chk("rst_busy", m.busy, 0);
        chk("rst_in_ready", m.in_ready, 0);
        chk("rst_out_valid", m.out_valid, 0);
        rst = 1'b1;
        m.out_ready = 1'b1;
        tick();
        m.out_ready = 1'b0;
        chk("early_out_ready_busy", m.busy, 0);

        pa[0] = 2; pb[0] = 3;
        pa[1] = 4; pb[1] = 5;
        pa[2] = 1; pb[2] = 1;
        run_job(3, 16'd5, 0, 0, 1'b0);
        chk("basic_d", m.d, 32);
        chk("basic_ovf", m.ovf, 0);

        run_job(0, 16'd7, 0, 1, 1'b0);
        chk("empty_d", m.d, 7);

        pa[0] = 1; pb[0] = 32'h20;
`ifdef CONF_INT_MAC_SAT_EN
        exp_ovf_d = 16'hFFFF;
`else
        exp_ovf_d = 16'h0010;
`endif
        run_job(1, 16'hFFF0, 0, 0, 1'b0);
        chk("ovf_d", m.d, exp_ovf_d);
        chk("ovf_flag", m.ovf, 1);

        pa[0] = 10; pb[0] = 11;
        pa[1] = 12; pb[1] = 13;
        run_job(2, 16'd1, 3, 4, 1'b1);
        chk("stall_job_d", m.d, 1 + 110 + 156);

        m.start = 1'b1;
        m.len   = 8'd4;
        m.bias  = 16'd100;
        tick();
        m.start    = 1'b0;
        m.in_valid = 1'b1;
        m.a        = 16'd2;
        m.b        = 16'd2;
        tick();
        m.in_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk("midrst_d", m.d, 0);
        chk("midrst_count", m.count, 0);
        chk("midrst_ovf", m.ovf, 0);
        chk("midrst_busy", m.busy, 0);
        chk("midrst_in_ready", m.in_ready, 0);
        chk("midrst_out_valid", m.out_valid, 0);
        rst = 1'b1;
        pa[0] = 3; pb[0] = 3;
        run_job(1, 16'd0, 0, 0, 1'b0);
        chk("after_rst_d", m.d, 9);

        for (int j = 0; j < 30; j++) begin
            int n;
            n = int'($urandom_range(0, 6));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    pa[i] = $urandom_range(16'hF000, 16'hFFFF);
                    pb[i] = $urandom_range(16'hF000, 16'hFFFF);
                end else begin
                    pa[i] = $urandom_range(0, 255);
                    pb[i] = $urandom_range(0, 255);
                end
            end
            run_job(n, 16'($urandom), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conf_int_mac_dot_seq.md
# conf_int_mac_dot_seq

Sequencer that drives one unsigned integer multiply-accumulate datapath (d = a*b + c) to compute a dot product of configurable length. Operand pairs stream in over a valid/ready handshake, and the accumulator is fed back as the addend. The final sum is presented over an output valid/ready handshake. The block sits between an operand producer (memory reader or FIFO) and a result consumer in the configurable-MAC test designs.

## Interface
- DATA_PATH_BITWIDTH, 16: width of a, b, bias, accumulator and d.
- LEN_BITWIDTH, 8: width of len and count.

- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  begins a job; honoured only in IDLE.
- len  in  LEN_BITWIDTH  number of operand pairs, sampled with start.
- bias  in  DATA_PATH_BITWIDTH  initial accumulator value, sampled with start.
- busy  out  1  high in RUN and DONE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts a pair this cycle.
- a, b  in  DATA_PATH_BITWIDTH  operand pair.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- d  out  DATA_PATH_BITWIDTH  accumulator value.
- count  out  LEN_BITWIDTH  pairs accepted in the current job.
- ovf  out  1  sticky overflow flag for the current job.

## Operation
- States:
  - IDLE: in_ready=0, out_valid=0, busy=0.
    - start=1 and len!=0: acc<=bias, count<=0, ovf<=0, latch len, go to RUN.
    - start=1 and len==0: acc<=bias, ovf<=0, go to DONE.
  - RUN: in_ready=1, busy=1.
    - Each handshake (in_valid & in_ready): acc <= acc + a*b, count <= count+1.
    - Handshake with count==len_latched-1: go to DONE.
  - DONE: out_valid=1, d=acc, in_ready=0.
    - out_ready=1: go to IDLE. acc, count and ovf hold until the next start.
- start outside IDLE is ignored. len and bias are not re-sampled.
- Arithmetic is unsigned. The product and sum are formed at 2*DATA_PATH_BITWIDTH+1 bits.
- ovf sets when the full-width sum exceeds 2^DATA_PATH_BITWIDTH-1.
- d equals acc in all states. It is valid to the consumer only while out_valid=1.
- in_valid=0 in RUN stalls indefinitely with no state change.

## Timing
- Reset values, applied on the first rising edge with rst=0: state=IDLE, acc=0, d=0, count=0, ovf=0, busy=0, in_ready=0, out_valid=0.
- Reset mid-job aborts the job. Partial results are discarded.
- start to in_ready=1: 1 cycle.
- Throughput in RUN: one pair per cycle.
- Last accepted pair to out_valid=1: 1 cycle. No pipeline stages inside the MAC path.
- out_ready to IDLE: 1 cycle. A new start is accepted in the cycle after the result handshake, not in the same cycle.
- out_ready high before out_valid has no effect.
- ovf becomes visible in the cycle after the overflowing handshake.

## Configuration
- CONF_INT_MAC_SAT_EN defined: the accumulator saturates at 2^DATA_PATH_BITWIDTH-1 and stays clamped for the rest of the job. ovf still sets.
- CONF_INT_MAC_SAT_EN undefined: the accumulator wraps modulo 2^DATA_PATH_BITWIDTH. ovf marks that a wrap occurred.

## Structure
- Package conf_int_mac_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - default width constants;
  - the saturation-max function.
- One sub-module, conf_int_mac_dot_dp, is combinational:
  - computes the wide a*b+acc;
  - produces the next accumulator and the overflow bit;
  - clamps to the saturation max only under CONF_INT_MAC_SAT_EN.
- The FSM, counter and registers live in conf_int_mac_dot_seq.

## Test plan
- Basic job: len=3, bias=5, pairs (2,3),(4,5),(1,1) streamed back-to-back.
  - Expect d=32, count=3, ovf=0.
  - out_valid rises 1 cycle after the third handshake.
- Empty job: len=0, bias=7.
  - Expect DONE directly, d=7, out_valid=1, no in_ready pulse.
- Overflow, W=16: bias=0xFFF0, pair (1,0x20).
  - Without the macro: d=0x0010, ovf=1.
  - With CONF_INT_MAC_SAT_EN: d=0xFFFF, ovf=1.
- Stalls and backpressure: len=2 with in_valid gaps of 3 cycles, then out_ready held low 4 cycles.
  - Expect d stable, out_valid held, no extra accumulation.
  - start pulses in RUN and DONE are ignored.
- Reset mid-job: rst=0 after one of four pairs.
  - Next cycle all outputs are at reset values.
  - A following job with len=1, bias=0, pair (3,3) yields d=9.
